// File: rtl/pulse_sync_pkg.sv
// Shared definitions for the pulse pending controller: per-channel FSM state
// encoding and the legal ranges of the block parameters.
package pulse_sync_pkg;

  localparam int unsigned CH_NUM_MIN        = 1;
  localparam int unsigned CH_NUM_MAX        = 16;
  localparam int unsigned PEND_CNT_SIZE_MIN = 2;
  localparam int unsigned PEND_CNT_SIZE_MAX = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_WAIT_LO = 2'd2
  } ch_state_e;

endpackage

// File: rtl/pulse_pend_ch.sv
// One pulse channel: pending-pulse counter plus 4-phase req/ack handshake FSM.
// Optional drop indication when PULSE_PEND_OVF_FLAG_EN is defined.
module pulse_pend_ch
  import pulse_sync_pkg::*;
#(
  parameter int unsigned PEND_CNT_SIZE = 3
) (
  input  logic                     clk_src,
  input  logic                     rst,
  input  logic                     d_in,
  input  logic                     ack,
  output logic                     req,
  output logic [PEND_CNT_SIZE-1:0] pend_cnt,
  output logic                     act_nxt_c
`ifdef PULSE_PEND_OVF_FLAG_EN
  ,
  output logic                     drop_c
`endif
);

  localparam int unsigned W = PEND_CNT_SIZE;
  localparam logic [W-1:0] CNT_MAX = '1;

  ch_state_e      state;
  ch_state_e      state_nxt;
  logic [W-1:0]   cnt_nxt;
  logic           launch_c;

  // State, counter and request registers
  always_ff @(posedge clk_src) begin
    if (rst) begin
      state    <= ST_IDLE;
      pend_cnt <= '0;
      req      <= 1'b0;
    end else begin
      state    <= state_nxt;
      pend_cnt <= cnt_nxt;
      req      <= (state_nxt == ST_REQ);
    end
  end

  // Next-state, launch decision and saturating pending-count update
  always_comb begin
    state_nxt = state;
    cnt_nxt   = pend_cnt;
    launch_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((pend_cnt != '0) || d_in) begin
          state_nxt = ST_REQ;
          launch_c  = 1'b1;
        end
      end
      ST_REQ: begin
        if (ack) state_nxt = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (!ack) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // A launch consumes one pulse; a coincident new pulse replaces it
    if (launch_c) begin
      if (!d_in) cnt_nxt = pend_cnt - W'(1);
    end else if (d_in && (pend_cnt != CNT_MAX)) begin
      cnt_nxt = pend_cnt + W'(1);
    end
    act_nxt_c = (state_nxt != ST_IDLE) || (cnt_nxt != '0);
  end

`ifdef PULSE_PEND_OVF_FLAG_EN
  // Pulse lost because the counter is full and nothing was launched
  assign drop_c = d_in && !launch_c && (pend_cnt == CNT_MAX);
`endif

endmodule

// File: rtl/pulse_pend_ctrl.sv
// Multi-channel pulse pending controller: every d_in pulse becomes one full
// req/ack handshake on its channel, with pulses queued in a saturating counter.
// Define PULSE_PEND_OVF_FLAG_EN to add the sticky per-channel ovf output.
module pulse_pend_ctrl
  import pulse_sync_pkg::*;
#(
  parameter int unsigned CH_NUM        = 4,
  parameter int unsigned PEND_CNT_SIZE = 3
) (
  input  logic                            clk_src,
  input  logic                            rst,
  input  logic [CH_NUM-1:0]               d_in,
  input  logic [CH_NUM-1:0]               ack,
  output logic [CH_NUM-1:0]               req,
  output logic [CH_NUM*PEND_CNT_SIZE-1:0] pend_cnt,
  output logic                            busy
`ifdef PULSE_PEND_OVF_FLAG_EN
  ,
  output logic [CH_NUM-1:0]               ovf
`endif
);

  logic [CH_NUM-1:0] act_nxt_c;
`ifdef PULSE_PEND_OVF_FLAG_EN
  logic [CH_NUM-1:0] drop_c;
`endif

  // Independent channel instances
  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    pulse_pend_ch #(
      .PEND_CNT_SIZE (PEND_CNT_SIZE)
    ) u_ch (
      .clk_src   (clk_src),
      .rst       (rst),
      .d_in      (d_in[i]),
      .ack       (ack[i]),
      .req       (req[i]),
      .pend_cnt  (pend_cnt[i*PEND_CNT_SIZE +: PEND_CNT_SIZE]),
      .act_nxt_c (act_nxt_c[i])
`ifdef PULSE_PEND_OVF_FLAG_EN
      ,
      .drop_c    (drop_c[i])
`endif
    );
  end

  // Busy flag tracks the registered channel activity, no path from d_in
  always_ff @(posedge clk_src) begin
    if (rst) busy <= 1'b0;
    else     busy <= |act_nxt_c;
  end

`ifdef PULSE_PEND_OVF_FLAG_EN
  // Sticky overflow per channel, cleared only by reset
  always_ff @(posedge clk_src) begin
    if (rst) ovf <= '0;
    else     ovf <= ovf | drop_c;
  end
`endif

endmodule

// File: tb/tb_pulse_pend_ctrl.sv
// Self-checking bench for pulse_pend_ctrl (CH_NUM=4, PEND_CNT_SIZE=3).
// Pulses are pushed to per-channel scoreboards; each req rise pops one entry.
module tb_pulse_pend_ctrl;

  localparam int unsigned CH_NUM = 4;
  localparam int unsigned PW     = 3;

  logic                   clk_src = 1'b0;
  logic                   rst     = 1'b1;
  logic [CH_NUM-1:0]      d_in    = '0;
  logic [CH_NUM-1:0]      ack;
  logic [CH_NUM-1:0]      req;
  logic [CH_NUM*PW-1:0]   pend_cnt;
  logic                   busy;
`ifdef PULSE_PEND_OVF_FLAG_EN
  logic [CH_NUM-1:0]      ovf;
`endif

  logic [CH_NUM-1:0]      ack_rsp = '0;
  logic [CH_NUM-1:0]      ack_frc = '0;
  assign ack = ack_rsp | ack_frc;

  always #5 clk_src = ~clk_src;

  pulse_pend_ctrl #(
    .CH_NUM        (CH_NUM),
    .PEND_CNT_SIZE (PW)
  ) dut (
    .clk_src  (clk_src),
    .rst      (rst),
    .d_in     (d_in),
    .ack      (ack),
    .req      (req),
    .pend_cnt (pend_cnt),
    .busy     (busy)
`ifdef PULSE_PEND_OVF_FLAG_EN
    ,
    .ovf      (ovf)
`endif
  );

  int ntot = 0;
  int nerr = 0;
  int sb [CH_NUM][$];
  int sent_id [CH_NUM];
  int hs_seen [CH_NUM];
  bit ack_en  [CH_NUM];
  int ack_dly [CH_NUM];
  int ack_hold[CH_NUM];
  int wcnt    [CH_NUM];
  int hcnt    [CH_NUM];
  logic [CH_NUM-1:0] req_prev = '0;

  function automatic logic [PW-1:0] cnt_of(input int c);
    return pend_cnt[c*PW +: PW];
  endfunction

  task automatic tick();
    @(posedge clk_src);
    #1;
  endtask

  // d_in = m for one cycle; channels in push_m are expected to handshake
  task automatic pulse(input logic [CH_NUM-1:0] m, input logic [CH_NUM-1:0] push_m);
    d_in = m;
    for (int c = 0; c < CH_NUM; c++) begin
      if (push_m[c]) begin
        sb[c].push_back(sent_id[c]);
        sent_id[c]++;
      end
    end
    tick();
    d_in = '0;
  endtask

  task automatic wait_idle(input int ch, output int peak);
    bit done = 1'b0;
    peak = int'(cnt_of(ch));
    for (int i = 0; i < 300; i++) begin
      if (busy === 1'b0 && ack === '0) begin
        done = 1'b1;
        break;
      end
      tick();
      if (int'(cnt_of(ch)) > peak) peak = int'(cnt_of(ch));
    end
    ntot++;
    if (!done) begin
      nerr++;
      $display("FAIL idle_timeout ch%0d: busy=%b ack=%b, required busy=0 ack=0", ch, busy, ack);
    end
  endtask

  // Ack responder: raises ack ack_dly cycles after req, holds it ack_hold cycles
  initial begin
    forever begin
      tick();
      for (int c = 0; c < CH_NUM; c++) begin
        if (!ack_en[c]) begin
          ack_rsp[c] = 1'b0;
          wcnt[c]    = 0;
        end else if (ack_rsp[c]) begin
          hcnt[c]++;
          if (hcnt[c] >= ack_hold[c]) begin
            ack_rsp[c] = 1'b0;
            wcnt[c]    = 0;
          end
        end else if (req[c]) begin
          wcnt[c]++;
          if (wcnt[c] >= ack_dly[c]) begin
            ack_rsp[c] = 1'b1;
            hcnt[c]    = 0;
          end
        end
      end
    end
  end

  // Monitor: each req rise must match the oldest outstanding pulse
  initial begin
    forever begin
      @(negedge clk_src);
      for (int c = 0; c < CH_NUM; c++) begin
        if (req[c] && !req_prev[c]) begin
          ntot++;
          if (sb[c].size() == 0) begin
            nerr++;
            $display("FAIL hs_unexpected ch%0d: got req rise, required none outstanding", c);
          end else begin
            int id;
            id = sb[c].pop_front();
            if (id !== hs_seen[c]) begin
              nerr++;
              $display("FAIL hs_order ch%0d: got pulse id %0d, required %0d", c, hs_seen[c], id);
            end
          end
          hs_seen[c]++;
        end
      end
      req_prev = req;
    end
  end

  task automatic test_reset();
    rst  = 1'b1;
    d_in = '1;
    tick();
    tick();
    rst  = 1'b0;
    d_in = '0;
    tick();
    ntot++;
    if (req !== '0) begin nerr++; $display("FAIL rst_req: got %b, required 0", req); end
    ntot++;
    if (pend_cnt !== '0) begin nerr++; $display("FAIL rst_cnt: got %h, required 0", pend_cnt); end
    ntot++;
    if (busy !== 1'b0) begin nerr++; $display("FAIL rst_busy: got %b, required 0", busy); end
`ifdef PULSE_PEND_OVF_FLAG_EN
    ntot++;
    if (ovf !== '0) begin nerr++; $display("FAIL rst_ovf: got %b, required 0", ovf); end
`endif
  endtask

  task automatic test_single();
    int peak;
    int h0;
    h0 = hs_seen[0];
    ack_dly[0] = 3; ack_hold[0] = 2; ack_en[0] = 1'b1;
    pulse(4'b0001, 4'b0001);
    ntot++;
    if (req !== 4'b0001) begin nerr++; $display("FAIL single_req: got %b, required 0001", req); end
    ntot++;
    if (busy !== 1'b1) begin nerr++; $display("FAIL single_busy: got %b, required 1", busy); end
    wait_idle(0, peak);
    ntot++;
    if (peak !== 0) begin nerr++; $display("FAIL single_cnt_peak: got %0d, required 0", peak); end
    ntot++;
    if (hs_seen[0] - h0 !== 1) begin nerr++; $display("FAIL single_hs: got %0d, required 1", hs_seen[0] - h0); end
    ntot++;
    if (req !== '0) begin nerr++; $display("FAIL single_req_end: got %b, required 0", req); end
  endtask

  task automatic test_back_to_back();
    int peak;
    int p2;
    int h0;
    h0 = hs_seen[1];
    ack_dly[1] = 4; ack_hold[1] = 1; ack_en[1] = 1'b1;
    for (int k = 0; k < 5; k++) pulse(4'b0010, 4'b0010);
    ntot++;
    if (cnt_of(1) !== 3'd4) begin nerr++; $display("FAIL b2b_cnt: got %0d, required 4", cnt_of(1)); end
    wait_idle(1, p2);
    peak = (p2 > 4) ? p2 : 4;
    ntot++;
    if (peak !== 4) begin nerr++; $display("FAIL b2b_peak: got %0d, required 4", peak); end
    ntot++;
    if (hs_seen[1] - h0 !== 5) begin nerr++; $display("FAIL b2b_hs: got %0d, required 5", hs_seen[1] - h0); end
  endtask

  task automatic test_saturate();
    int peak;
    int h0;
    h0 = hs_seen[2];
    ack_en[2] = 1'b0;
    for (int k = 0; k < 10; k++) pulse(4'b0100, (k < 8) ? 4'b0100 : 4'b0000);
    ntot++;
    if (cnt_of(2) !== 3'd7) begin nerr++; $display("FAIL sat_cnt: got %0d, required 7", cnt_of(2)); end
    ntot++;
    if (req[2] !== 1'b1) begin nerr++; $display("FAIL sat_req: got %b, required 1", req[2]); end
`ifdef PULSE_PEND_OVF_FLAG_EN
    ntot++;
    if (ovf !== 4'b0100) begin nerr++; $display("FAIL sat_ovf: got %b, required 0100", ovf); end
`endif
    ack_dly[2] = 1; ack_hold[2] = 1; ack_en[2] = 1'b1;
    wait_idle(2, peak);
    ntot++;
    if (hs_seen[2] - h0 !== 8) begin nerr++; $display("FAIL sat_hs: got %0d, required 8", hs_seen[2] - h0); end
`ifdef PULSE_PEND_OVF_FLAG_EN
    ntot++;
    if (ovf !== 4'b0100) begin nerr++; $display("FAIL sat_ovf_sticky: got %b, required 0100", ovf); end
`endif
  endtask

  task automatic test_coincident();
    int peak;
    ack_dly[3] = 2; ack_hold[3] = 1; ack_en[3] = 1'b1;
    pulse(4'b1000, 4'b1000);
    ntot++;
    if (cnt_of(3) !== 3'd0) begin nerr++; $display("FAIL coinc_cnt: got %0d, required 0", cnt_of(3)); end
    ntot++;
    if (req[3] !== 1'b1) begin nerr++; $display("FAIL coinc_req: got %b, required 1", req[3]); end
    wait_idle(3, peak);
  endtask

  task automatic test_all_channels();
    int peak;
    int h0 [CH_NUM];
    int bad_ch;
    bad_ch = 0;
    for (int c = 0; c < CH_NUM; c++) begin
      h0[c] = hs_seen[c];
      ack_dly[c] = c + 1; ack_hold[c] = 2; ack_en[c] = 1'b1;
    end
    pulse(4'b1111, 4'b1111);
    ntot++;
    if (req !== 4'b1111) begin nerr++; $display("FAIL all_req: got %b, required 1111", req); end
    ntot++;
    if (pend_cnt !== '0) begin nerr++; $display("FAIL all_cnt: got %h, required 0", pend_cnt); end
    wait_idle(0, peak);
    for (int c = 0; c < CH_NUM; c++) if (hs_seen[c] - h0[c] != 1) bad_ch++;
    ntot++;
    if (bad_ch !== 0) begin nerr++; $display("FAIL all_hs: got %0d channels without exactly one handshake, required 0", bad_ch); end
  endtask

  task automatic test_reset_mid();
    int bad;
    bad = 0;
    ack_en[0] = 1'b0;
    for (int k = 0; k < 4; k++) pulse(4'b0001, 4'b0001);
    ntot++;
    if (cnt_of(0) !== 3'd3 || req[0] !== 1'b1) begin
      nerr++;
      $display("FAIL rmid_pre: got cnt=%0d req=%b, required cnt=3 req=1", cnt_of(0), req[0]);
    end
    rst = 1'b1;
    ack_frc[0] = 1'b1;
    tick();
    rst = 1'b0;
    sb[0].delete();
    sent_id[0] = hs_seen[0];
    ntot++;
    if (req !== '0) begin nerr++; $display("FAIL rmid_req: got %b, required 0", req); end
    ntot++;
    if (pend_cnt !== '0) begin nerr++; $display("FAIL rmid_cnt: got %h, required 0", pend_cnt); end
    ntot++;
    if (busy !== 1'b0) begin nerr++; $display("FAIL rmid_busy: got %b, required 0", busy); end
`ifdef PULSE_PEND_OVF_FLAG_EN
    ntot++;
    if (ovf !== '0) begin nerr++; $display("FAIL rmid_ovf: got %b, required 0", ovf); end
`endif
    for (int k = 0; k < 3; k++) begin
      tick();
      if (req !== '0 || busy !== 1'b0) bad++;
    end
    ntot++;
    if (bad !== 0) begin nerr++; $display("FAIL rmid_no_launch: got %0d active cycles, required 0", bad); end
    ack_frc[0] = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_saturate();
    test_coincident();
    test_all_channels();
    test_reset_mid();
    tick();
    for (int c = 0; c < CH_NUM; c++) begin
      ntot++;
      if (sb[c].size() !== 0) begin
        nerr++;
        $display("FAIL sb_leftover ch%0d: got %0d outstanding, required 0", c, sb[c].size());
      end
    end
    $display("test done: total=%0d bad=%0d", ntot, nerr);
    $finish;
  end

endmodule
